move_pulse_gen: RTL and testbench
=================================

Name: move_pulse_gen

Overview:
- Input conditioner directly upstream of the playfield light cells.
- Converts two raw active-low board keys (left/right) into clean one-cycle L and R move pulses.
- Per key: two-flop synchroniser, debounce FSM, press-edge pulse. Simultaneous presses are arbitrated so a tie produces no move.
- L/R fan out to every light cell in the row; NL/NR remain neighbour-cell wiring outside this block.

Parameters:
- DB_CYCLES, 16, consecutive stable cycles required to accept a press or a release (legal range >= 2).
- REPEAT_CYCLES, 64, auto-repeat interval in cycles; used only when AUTOREPEAT_EN is defined (legal range >= 2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- key_l_n  input  1  raw left key, active-low, asynchronous to clk
- key_r_n  input  1  raw right key, active-low, asynchronous to clk
- L  output  1  one-cycle left-move pulse, registered
- R  output  1  one-cycle right-move pulse, registered

Behaviour:
- Reset (asynchronous, active-high), applied at any time including mid-debounce or mid-HELD:
  - sync flops -> 1 (released); both FSMs -> IDLE; all counters -> 0; L=0, R=0, immediately without waiting for a clk edge.
  - After reset deasserts, a key already held low must be re-qualified from IDLE.
- Synchroniser: two flops per key. pressed_x = ~sync2_x. No logic reads the raw key or sync1.
- Per-channel FSM, states IDLE, DB_PRESS, HELD, DB_REL; debounce counter width $clog2(DB_CYCLES):
  - IDLE: pressed -> DB_PRESS, cnt<=0; else stay.
  - DB_PRESS: !pressed -> IDLE, cnt<=0 (bounce rejected); pressed & cnt==DB_CYCLES-1 -> HELD and raise press_x; else cnt<=cnt+1.
  - HELD: !pressed -> DB_REL, cnt<=0; else stay. No further pulses unless AUTOREPEAT_EN is defined.
  - DB_REL: pressed -> HELD, no pulse (release bounce); !pressed & cnt==DB_CYCLES-1 -> IDLE; else cnt<=cnt+1.
- Latency: key low and stable before edge 0 -> pulse high for exactly the one cycle after edge DB_CYCLES+2 (DB_CYCLES=16 -> after edge 18). There are no other pulses per press.
- Arbitration:
  - L <= press_l & ~press_r; R <= press_r & ~press_l.
  - Both requests in the same cycle -> both dropped, L=R=0. The tie is not deferred or queued.
  - Requests in different cycles are each emitted, even while the other key is HELD.
- L and R are never both 1 in any cycle.
- Each output is high for at most one consecutive cycle.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- Defined:
  - Each channel has a repeat counter, cleared on entry to HELD.
  - While in HELD or DB_REL, the channel raises press_x every REPEAT_CYCLES cycles after the initial pulse (first repeat REPEAT_CYCLES cycles after it).
  - The counter clears on return to HELD from DB_REL.
  - Repeats pass through the same tie arbitration.
- Undefined: repeat counter and logic absent; exactly one pulse per qualified press.

Test Plan:
- Reset, then key_l_n=0 held for 30 cycles (DB_CYCLES=4) -> L=1 for exactly one cycle after edge 6 counting the first sampling edge as 0; R=0 throughout.
- key_r_n low for 3 cycles, high for 3 cycles, low for 2 cycles (DB_CYCLES=4) -> R stays 0, FSM returns to IDLE.
- Both keys driven low on the same cycle and held 20 cycles -> L=0 and R=0 for all 20 cycles.
- key_l_n low at cycle 0, key_r_n low at cycle 5, both held (DB_CYCLES=4) -> one L pulse, then one R pulse 5 cycles later; never both high.
- key_l_n held low, reset asserted mid-DB_PRESS for 1 cycle then released with key still low -> L=0 during reset, then one L pulse DB_CYCLES+3 edges after reset release.
- AUTOREPEAT_EN defined, REPEAT_CYCLES=8, DB_CYCLES=4, key_l_n held 40 cycles -> initial L pulse, then L pulses every 8 cycles until the release debounce completes.

Source files
------------

// File: rtl/move_pulse_gen.sv
// move_pulse_gen: turns two raw active-low board keys into clean one-cycle
// left/right move pulses for the playfield light-cell row.
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   key_l_n  raw left key, active-low, asynchronous to clk
//   key_r_n  raw right key, active-low, asynchronous to clk
//   L        registered one-cycle left-move pulse
//   R        registered one-cycle right-move pulse
//
// Parameters:
//   DB_CYCLES      stable cycles needed to accept a press or a release (>= 2)
//   REPEAT_CYCLES  auto-repeat interval in cycles (>= 2)
//
// Build option:
//   AUTOREPEAT_EN  when defined, a held key re-issues its move request every
//                  REPEAT_CYCLES cycles after the initial pulse. When not
//                  defined, each qualified press yields exactly one pulse.

// ---------------------------------------------------------------------------
// move_pulse_chan: one key channel. Two-flop synchroniser, debounce FSM and
// press-request generation. The request is combinational; the top registers
// it after arbitration.
// ---------------------------------------------------------------------------
module move_pulse_chan #(
    parameter int DB_CYCLES     = 16,
    parameter int REPEAT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    // Out-of-range parameters stop elaboration.
    if (DB_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("move_pulse_chan: DB_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } state_t;

    logic          sync1;
    logic          sync2;
    logic          pressed;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          cnt_last;
    logic          press_db;

    // Synchroniser resets to the released level so nothing fires on
    // reset release; a key already held low is re-qualified from IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign pressed  = ~sync2;
    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_db  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pressed) begin
                    state_nxt = DB_PRESS;
                    cnt_nxt   = '0;
                end
            end
            DB_PRESS: begin
                if (!pressed) begin
                    // Press bounce: start over.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt_last) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    press_db  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_nxt = DB_REL;
                    cnt_nxt   = '0;
                end
            end
            DB_REL: begin
                if (pressed) begin
                    // Release bounce: back to HELD without a new pulse.
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt_last) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_nxt;
    logic          rep_fire;
    logic          rep_active;
    logic          enter_held;

    // Repeat phase is measured from the last entry into HELD, which is
    // also the edge of the initial pulse for a fresh press.
    assign rep_active = (state == HELD) || (state == DB_REL);
    assign enter_held = (state_nxt == HELD) && (state != HELD);

    always_comb begin
        rep_nxt  = rep_cnt;
        rep_fire = 1'b0;
        if (rep_active && (rep_cnt == REP_LAST)) begin
            rep_fire = 1'b1;
        end
        if (enter_held) begin
            rep_nxt = '0;
        end else if (rep_active) begin
            rep_nxt = rep_fire ? '0 : rep_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_nxt;
        end
    end

    assign press = press_db | rep_fire;
`else
    assign press = press_db;
`endif

endmodule

// ---------------------------------------------------------------------------
// move_pulse_gen: two channels plus tie arbitration. A same-cycle request
// from both keys is dropped rather than deferred.
// ---------------------------------------------------------------------------
module move_pulse_gen #(
    parameter int DB_CYCLES     = 16,
    parameter int REPEAT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic key_l_n,
    input  logic key_r_n,
    output logic L,
    output logic R
);

    logic press_l;
    logic press_r;

    move_pulse_chan #(
        .DB_CYCLES    (DB_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_chan_l (
        .clk  (clk),
        .reset(reset),
        .key_n(key_l_n),
        .press(press_l)
    );

    move_pulse_chan #(
        .DB_CYCLES    (DB_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_chan_r (
        .clk  (clk),
        .reset(reset),
        .key_n(key_r_n),
        .press(press_r)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            L <= 1'b0;
            R <= 1'b0;
        end else begin
            L <= press_l & ~press_r;
            R <= press_r & ~press_l;
        end
    end

endmodule

// File: tb/tb_move_pulse_gen.sv
// tb_move_pulse_gen: directed, table-driven bench for move_pulse_gen
// with DB_CYCLES=4 and REPEAT_CYCLES=8.
module tb_move_pulse_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_l_n = 1'b1;
    logic key_r_n = 1'b1;
    logic L;
    logic R;

    int checks = 0;
    int errors = 0;

    move_pulse_gen #(
        .DB_CYCLES    (4),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .key_l_n(key_l_n),
        .key_r_n(key_r_n),
        .L      (L),
        .R      (R)
    );

    always #5 clk = ~clk;

    // Bit c of a pattern refers to clock edge c after reset release
    // (first edge = 0): key pressed at that edge / pulse visible after it.
    typedef struct {
        string       name;
        int          len;
        logic [63:0] l_pat;
        logic [63:0] r_pat;
        logic [63:0] exp_l;
        logic [63:0] exp_r;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] span(input int a, input int b);
        logic [63:0] m;
        m = '0;
        for (int i = a; i <= b; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] at(input int n);
        return span(n, n);
    endfunction

    task automatic add(input string nm, input int len,
                       input logic [63:0] lp, input logic [63:0] rp,
                       input logic [63:0] el, input logic [63:0] er);
        vec_t v;
        v.name  = nm;
        v.len   = len;
        v.l_pat = lp;
        v.r_pat = rp;
        v.exp_l = el;
        v.exp_r = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves reset released just after an edge; the next edge is edge 0.
    task automatic do_reset(input string nm);
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        reset   = 1'b1;
        tick();
        tick();
        chk({nm, " rst L"}, L, 1'b0);
        chk({nm, " rst R"}, R, 1'b0);
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        do_reset(v.name);
        for (int c = 0; c < v.len; c++) begin
            key_l_n = ~v.l_pat[c];
            key_r_n = ~v.r_pat[c];
            tick();
            chk($sformatf("%s L c%0d", v.name, c), L, v.exp_l[c]);
            chk($sformatf("%s R c%0d", v.name, c), R, v.exp_r[c]);
            chk($sformatf("%s excl c%0d", v.name, c), L & R, 1'b0);
        end
        key_l_n = 1'b1;
        key_r_n = 1'b1;
    endtask

    initial begin
`ifdef AUTOREPEAT_EN
        add("ar_l_hold", 50, span(0, 37), '0,
            at(6) | at(14) | at(22) | at(30) | at(38), '0);
        add("ar_tie", 40, span(0, 29), span(0, 29), '0, '0);
        add("ar_stagger", 45, span(0, 29), span(1, 30),
            at(6) | at(14) | at(22) | at(30),
            at(7) | at(15) | at(23) | at(31));
`else
        add("l_hold30", 40, span(0, 29), '0, at(6), '0);
        add("r_bounce", 20, '0, span(0, 2) | span(6, 7), '0, '0);
        add("tie_hold", 30, span(0, 19), span(0, 19), '0, '0);
        add("l_then_r", 50, span(0, 39), span(5, 39), at(6), at(11));
        add("r_then_l", 40, span(3, 30), span(0, 30), at(9), at(6));
        add("near_tie", 30, span(0, 20), span(1, 20), at(6), at(7));
        add("l_min_press", 20, span(0, 4), '0, at(6), '0);
        add("l_short", 20, span(0, 3), '0, '0, '0);
        add("l_rel_bounce", 40, span(0, 19) | span(22, 29), '0,
            at(6), '0);
        add("l_twice", 40, span(0, 9) | span(20, 35), '0,
            at(6) | at(26), '0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of DB_PRESS with the key still held.
        do_reset("mid_db");
        key_l_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("mid_db pre L c%0d", c), L, 1'b0);
        end
        reset = 1'b1;
        #1;
        chk("mid_db async L", L, 1'b0);
        tick();
        chk("mid_db rst L", L, 1'b0);
        chk("mid_db rst R", R, 1'b0);
        reset = 1'b0;
        for (int c = 0; c < 11; c++) begin
            tick();
            chk($sformatf("mid_db L c%0d", c), L, (c == 6));
            chk($sformatf("mid_db R c%0d", c), R, 1'b0);
        end

        // Reset while the pulse is high clears it without a clock edge,
        // then the still-held key is re-qualified from IDLE.
        do_reset("held");
        key_l_n = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tick();
            chk($sformatf("held pre L c%0d", c), L, (c == 6));
        end
        #2;
        reset = 1'b1;
        #1;
        chk("held async L", L, 1'b0);
        tick();
        chk("held rst L", L, 1'b0);
        reset = 1'b0;
        for (int c = 0; c < 11; c++) begin
            tick();
            chk($sformatf("held requal L c%0d", c), L, (c == 6));
        end
        key_l_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
